// File: rtl/nag_pkg.sv
// rtl/nag_pkg.sv - shared state type and config helpers for the nested address generator
package nag_pkg;

  localparam int NAG_FIELD_W = 32;
  localparam int NAG_PACK_W  = 512;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } nag_state_t;

  // Pull dimension d (aw bits wide) out of a packed per-dimension config bus.
  function automatic logic [NAG_FIELD_W-1:0] unpack_field(
    input logic [NAG_PACK_W-1:0] vec,
    input int unsigned           d,
    input int unsigned           aw
  );
    logic [NAG_PACK_W-1:0] sh;
    sh = vec >> (d * aw);
    return NAG_FIELD_W'(sh) & ((NAG_FIELD_W'(1) << aw) - NAG_FIELD_W'(1));
  endfunction

  function automatic logic [NAG_FIELD_W-1:0] eff_size(input logic [NAG_FIELD_W-1:0] s);
    return (s == '0) ? NAG_FIELD_W'(1) : s;
  endfunction

endpackage

// File: rtl/nag_dim_counter.sv
// rtl/nag_dim_counter.sv - one loop dimension: index plus running address accumulator
module nag_dim_counter #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          inc,
  input  logic [AW-1:0] ld_acc,
  input  logic [AW-1:0] stride,
  output logic [AW-1:0] idx,
  output logic [AW-1:0] acc,
  output logic [AW-1:0] acc_next
);

  assign acc_next = acc + stride;

  // clear restarts this dimension at ld_acc and wins over inc
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
      acc <= '0;
    end else if (clear) begin
      idx <= '0;
      acc <= ld_acc;
    end else if (inc) begin
      idx <= idx + AW'(1);
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/nested_addr_gen_bp.sv
// rtl/nested_addr_gen_bp.sv - nested-loop address generator with valid/ready backpressure
module nested_addr_gen_bp
  import nag_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                init_pulse,
  input  logic [AW-1:0]       req_num,
  input  logic [AW-1:0]       base,
  input  logic [DEPTH*AW-1:0] size,
  input  logic [DEPTH*AW-1:0] stride,
  input  logic                wrap_en,
  output logic [AW-1:0]       addr,
  output logic                addr_vld,
  input  logic                addr_rdy,
  output logic [DEPTH-1:0]    last,
  output logic                busy,
  output logic                done
);

  nag_state_t       state;
  logic [AW-1:0]    req_q;
  logic [AW-1:0]    base_q;
  logic [AW-1:0]    cnt;
  logic             wrap_q;
  logic [AW-1:0]    size_last [DEPTH];
  logic [AW-1:0]    stride_q [DEPTH];
  logic [AW-1:0]    size_last_in [DEPTH];
  logic [AW-1:0]    stride_in [DEPTH];
  logic [AW-1:0]    idx [DEPTH];
  logic [AW-1:0]    acc [DEPTH];
  logic [AW-1:0]    acc_next [DEPTH];
  logic [DEPTH-1:0] at_last;
  logic [DEPTH-1:0] last_raw;
  logic [DEPTH-1:0] dim_clear;
  logic [DEPTH-1:0] dim_inc;
  logic [AW-1:0]    ld_acc;
  logic [AW-1:0]    carry_src;
  logic             xfer;
  logic             cnt_hit;
  logic             do_init;
  logic             do_wrap;
  logic             do_adv;

  for (genvar d = 0; d < DEPTH; d++) begin : g_dim
    assign stride_in[d]    = AW'(unpack_field(NAG_PACK_W'(stride), d, AW));
    assign size_last_in[d] = AW'(eff_size(unpack_field(NAG_PACK_W'(size), d, AW)) - NAG_FIELD_W'(1));
    assign at_last[d]      = (idx[d] == size_last[d]);

    nag_dim_counter #(.AW(AW)) u_dim (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (dim_clear[d]),
      .inc      (dim_inc[d]),
      .ld_acc   (ld_acc),
      .stride   (stride_q[d]),
      .idx      (idx[d]),
      .acc      (acc[d]),
      .acc_next (acc_next[d])
    );
  end

  always_comb begin
    logic run_last;
    run_last = 1'b1;
    for (int d = 0; d < DEPTH; d++) begin
      run_last    = run_last & at_last[d];
      last_raw[d] = run_last;
    end
  end

  assign xfer    = (state == RUN) && addr_vld && addr_rdy;
  assign cnt_hit = ((cnt + AW'(1)) == req_q);
  assign do_init = init_pulse && (req_num != '0);
  assign do_wrap = !init_pulse && xfer && !cnt_hit && last_raw[DEPTH-1] && wrap_q;
  assign do_adv  = !init_pulse && xfer && !cnt_hit && !last_raw[DEPTH-1];

  // The lowest non-exhausted dimension steps; every dimension below it reloads from its new sum.
  always_comb begin
    logic below;
    below     = 1'b1;
    carry_src = acc_next[0];
    for (int d = 0; d < DEPTH; d++) begin
      if (below) carry_src = acc_next[d];
      dim_inc[d]   = do_adv & below & ~at_last[d];
      dim_clear[d] = do_init | do_wrap | (do_adv & below & at_last[d]);
      below        = below & at_last[d];
    end
  end

  assign ld_acc = do_init ? base : (do_wrap ? base_q : carry_src);
  assign addr   = acc[0];
  assign last   = addr_vld ? last_raw : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      req_q    <= '0;
      base_q   <= '0;
      wrap_q   <= 1'b0;
      for (int d = 0; d < DEPTH; d++) begin
        size_last[d] <= '0;
        stride_q[d]  <= '0;
      end
    end else begin
      done <= 1'b0;
      if (init_pulse) begin
        req_q  <= req_num;
        base_q <= base;
        wrap_q <= wrap_en;
        cnt    <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          size_last[d] <= size_last_in[d];
          stride_q[d]  <= stride_in[d];
        end
        if (req_num != '0) begin
          state    <= RUN;
          addr_vld <= 1'b1;
          busy     <= 1'b1;
        end else begin
          state    <= FIN;
          addr_vld <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (xfer) begin
              cnt <= cnt + AW'(1);
              if (cnt_hit || (last_raw[DEPTH-1] && !wrap_q)) begin
                state    <= FIN;
                addr_vld <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nested_addr_gen_bp.sv
// tb/tb_nested_addr_gen_bp.sv - randomized model-checked bench for nested_addr_gen_bp
module tb_nested_addr_gen_bp;

  localparam int AW    = 16;
  localparam int DEPTH = 6;

  typedef struct {
    logic [AW-1:0]    a;
    logic [DEPTH-1:0] l;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                init_pulse = 1'b0;
  logic                wrap_en = 1'b0;
  logic                addr_rdy = 1'b0;
  logic [AW-1:0]       req_num = '0;
  logic [AW-1:0]       base = '0;
  logic [DEPTH*AW-1:0] size = '0;
  logic [DEPTH*AW-1:0] stride = '0;
  logic [AW-1:0]       addr;
  logic                addr_vld;
  logic [DEPTH-1:0]    last;
  logic                busy;
  logic                done;

  int  total = 0;
  int  bad = 0;
  int  done_seen = 0;
  int  rdy_mode = 0;
  int  rdy_phase = 0;
  bit  chk_en = 1'b0;
  bit  done_due = 1'b0;
  bit  stall_prev = 1'b0;
  logic [AW-1:0]    prev_addr = '0;
  logic [DEPTH-1:0] prev_last = '0;
  exp_t exp_q[$];

  int r_req;
  int r_base;
  bit r_wrap;
  int r_size[DEPTH];
  int r_stride[DEPTH];

  nested_addr_gen_bp #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .init_pulse (init_pulse),
    .req_num    (req_num),
    .base       (base),
    .size       (size),
    .stride     (stride),
    .wrap_en    (wrap_en),
    .addr       (addr),
    .addr_vld   (addr_vld),
    .addr_rdy   (addr_rdy),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Address k of the run is flat nest point k (mod volume when wrapping), decoded mixed-radix.
  function automatic void build_expected();
    longint vol, n, i, id, e;
    logic [AW-1:0]    a;
    logic [DEPTH-1:0] at, l;
    exp_t x;
    exp_q.delete();
    vol = 1;
    for (int d = 0; d < DEPTH; d++) vol *= (r_size[d] == 0) ? 1 : r_size[d];
    n = r_wrap ? longint'(r_req) : ((longint'(r_req) < vol) ? longint'(r_req) : vol);
    for (longint k = 0; k < n; k++) begin
      i = k % vol;
      a = AW'(r_base);
      for (int d = 0; d < DEPTH; d++) begin
        e     = (r_size[d] == 0) ? 1 : r_size[d];
        id    = i % e;
        i     = i / e;
        a     = a + AW'(id * longint'(r_stride[d]));
        at[d] = (id == e - 1);
      end
      l[0] = at[0];
      for (int d = 1; d < DEPTH; d++) l[d] = l[d-1] & at[d];
      x.a = a;
      x.l = l;
      exp_q.push_back(x);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       addr_rdy = 1'b1;
      1:       addr_rdy = (rdy_phase % 3 == 0);
      default: addr_rdy = 1'($urandom_range(0, 1));
    endcase
    rdy_phase++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("addr_vld", 32'(addr_vld), 32'(exp_q.size() != 0));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("done", 32'(done), 32'(done_due));
      if (done) done_seen++;
      done_due = 1'b0;
      if (stall_prev) begin
        chk("stall_addr", 32'(addr), 32'(prev_addr));
        chk("stall_last", 32'(last), 32'(prev_last));
      end
      if (addr_vld && exp_q.size() != 0) begin
        chk("addr", 32'(addr), 32'(exp_q[0].a));
        chk("last", 32'(last), 32'(exp_q[0].l));
        if (addr_rdy) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
      stall_prev = addr_vld && !addr_rdy;
      prev_addr  = addr;
      prev_last  = last;
    end
  end

  task automatic start_run();
    @(posedge clk);
    #1;
    req_num = AW'(r_req);
    base    = AW'(r_base);
    wrap_en = r_wrap;
    for (int d = 0; d < DEPTH; d++) begin
      size[d*AW +: AW]   = AW'(r_size[d]);
      stride[d*AW +: AW] = AW'(r_stride[d]);
    end
    init_pulse = 1'b1;
    @(posedge clk);
    #1;
    init_pulse = 1'b0;
    build_expected();
    done_due   = (exp_q.size() == 0);
    stall_prev = 1'b0;
    req_num = AW'($urandom);
    base    = AW'($urandom);
    wrap_en = 1'($urandom_range(0, 1));
    size    = {$urandom, $urandom, $urandom};
    stride  = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int base_cnt, input int limit, input string nm);
    int c;
    c = 0;
    while (done_seen == base_cnt && c < limit) begin
      @(posedge clk);
      c++;
    end
    chk(nm, 32'(done_seen - base_cnt), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic cfg_basic(input int b);
    r_req    = 12;
    r_base   = b;
    r_wrap   = 1'b0;
    r_size   = '{4, 3, 1, 1, 1, 1};
    r_stride = '{1, 16, 0, 0, 0, 0};
  endtask

  task automatic cfg_long();
    r_req    = 64;
    r_base   = 0;
    r_wrap   = 1'b0;
    r_size   = '{4, 4, 4, 1, 1, 1};
    r_stride = '{1, 4, 16, 0, 0, 0};
  endtask

  initial begin
    int db;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_vld", 32'(addr_vld), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    rdy_mode = 0;
    cfg_basic(32'h100);
    db = done_seen;
    start_run();
    chk("model_basic_n", 32'(exp_q.size()), 32'd12);
    chk("model_basic_a4", 32'(exp_q[4].a), 32'h110);
    chk("model_basic_a11", 32'(exp_q[11].a), 32'h123);
    chk("model_basic_l3", 32'(exp_q[3].l), 32'h01);
    chk("model_basic_l11", 32'(exp_q[11].l), 32'h3f);
    wait_done(db, 40, "basic_done");

    rdy_mode = 1;
    cfg_basic(32'h100);
    db = done_seen;
    start_run();
    wait_done(db, 80, "bp_done");

    rdy_mode = 0;
    r_req = 6; r_base = 0; r_wrap = 1'b1;
    r_size   = '{2, 2, 1, 1, 1, 1};
    r_stride = '{4, 8, 0, 0, 0, 0};
    db = done_seen;
    start_run();
    chk("model_wrap_n", 32'(exp_q.size()), 32'd6);
    chk("model_wrap_a4", 32'(exp_q[4].a), 32'd0);
    chk("model_wrap_a5", 32'(exp_q[5].a), 32'd4);
    wait_done(db, 40, "wrap_done");

    r_wrap = 1'b0;
    db = done_seen;
    start_run();
    chk("model_nowrap_n", 32'(exp_q.size()), 32'd4);
    chk("model_nowrap_a3", 32'(exp_q[3].a), 32'd12);
    wait_done(db, 40, "nowrap_done");

    r_req = 0;
    db = done_seen;
    start_run();
    chk("model_zero_n", 32'(exp_q.size()), 32'd0);
    wait_done(db, 5, "zero_done");

    r_req = 3; r_base = 32'hFFFE; r_wrap = 1'b0;
    r_size   = '{3, 1, 1, 1, 1, 1};
    r_stride = '{3, 0, 0, 0, 0, 0};
    db = done_seen;
    start_run();
    chk("model_ovf_a1", 32'(exp_q[1].a), 32'h0001);
    chk("model_ovf_a2", 32'(exp_q[2].a), 32'h0004);
    wait_done(db, 20, "ovf_done");

    rdy_mode = 2;
    cfg_long();
    db = done_seen;
    start_run();
    repeat (5) @(posedge clk);
    cfg_basic(32'h200);
    start_run();
    chk("model_abort_a0", 32'(exp_q[0].a), 32'h200);
    wait_done(db, 200, "abort_done");

    rdy_mode = 0;
    cfg_long();
    start_run();
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_vld", 32'(addr_vld), 32'd1);
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_vld", 32'(addr_vld), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_last", 32'(last), 32'd0);
    chk("async_addr", 32'(addr), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    done_due   = 1'b0;
    stall_prev = 1'b0;
    chk_en     = 1'b1;
    repeat (4) @(posedge clk);

    rdy_mode = 2;
    for (int t = 0; t < 10; t++) begin
      r_req  = int'($urandom_range(0, 40));
      r_base = int'($urandom_range(0, 65535));
      r_wrap = 1'($urandom_range(0, 1));
      for (int d = 0; d < DEPTH; d++) begin
        r_size[d]   = int'($urandom_range(0, 4));
        r_stride[d] = int'($urandom_range(0, 65535));
      end
      db = done_seen;
      start_run();
      wait_done(db, 400, "rand_done");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
